// File: rtl/ps2_line_buf_pkg.sv
// Shared keyboard code constants, status bit positions and state encodings
// for the PS/2 keyboard path and its line-buffer consumer.
package ps2_line_buf_pkg;

  localparam logic [7:0] KC_BREAK    = 8'hF0;
  localparam logic [7:0] KC_CR       = 8'h0D;
  localparam logic [7:0] KC_BS       = 8'h08;
  localparam logic [7:0] KC_UNK      = 8'h23;
  localparam logic [7:0] KC_PRINT_LO = 8'h20;
  localparam logic [7:0] KC_PRINT_HI = 8'h7E;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_POP    = 2'd1,
    ST_APPLY  = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    CLS_DROP  = 3'd0,
    CLS_BREAK = 3'd1,
    CLS_BS    = 3'd2,
    CLS_CR    = 3'd3,
    CLS_PRINT = 3'd4
  } cls_e;

  // Priority classification of a popped byte; a pending break is handled by the caller.
  function automatic cls_e classify(input logic [7:0] b);
    cls_e c;
    if (b == KC_BREAK) begin
      c = CLS_BREAK;
    end else if (b == KC_UNK) begin
      c = CLS_DROP;
    end else if (b == KC_BS) begin
      c = CLS_BS;
    end else if (b == KC_CR) begin
      c = CLS_CR;
    end else if ((b >= KC_PRINT_LO) && (b <= KC_PRINT_HI)) begin
      c = CLS_PRINT;
    end else begin
      c = CLS_DROP;
    end
    return c;
  endfunction

endpackage

// File: rtl/ps2_line_buf_line_ram.sv
// Line character store: one synchronous write port, one registered read port
// (a same-address write and read in one cycle returns the old contents).
module line_ram #(
  parameter int LINE_LEN = 32,
  parameter int AW       = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o
);

  logic [7:0] mem_q [LINE_LEN];
  logic [7:0] rd_q;

  // Write port; a reset cycle suppresses any in-flight write.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && !rst_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q <= 8'h00;
    end else begin
      rd_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/ps2_line_buf.sv
// Pops ASCII bytes from the keyboard FIFO, filters break sequences, edits a line
// with backspace and holds it for the host until acknowledged.
module ps2_line_buf
  import ps2_line_buf_pkg::*;
#(
  parameter  int LINE_LEN = 32,
  localparam int AW       = $clog2(LINE_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   kb_status,
  input  logic [31:0]   kb_data,
  output logic          fifo_rd,
  output logic          line_ready,
  output logic [AW:0]   line_len,
  output logic          overflow,
  input  logic          line_ack,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_char
);

  localparam logic [AW:0] LEN_MAX = (AW+1)'(LINE_LEN);
  localparam logic [AW:0] LEN_ONE = {{AW{1'b0}}, 1'b1};

  state_e      state_q, state_d;
  logic [7:0]  byte_q, byte_d;
  logic        break_pend_q, break_pend_d;
  logic        line_ready_q, line_ready_d;
  logic [AW:0] line_len_q, line_len_d;
  logic        overflow_q, overflow_d;
  logic        fifo_rd_q, fifo_rd_d;
  logic        wr_en_s;
  logic        kb_empty_s;
  logic        unused_kb_bits_s;

  assign kb_empty_s       = kb_status[STAT_EMPTY];
  assign unused_kb_bits_s = ^{kb_status[31:1], kb_data[31:8]};

  // Next-state and datapath update for the pop/apply/lock sequencer.
  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    break_pend_d = break_pend_q;
    line_ready_d = line_ready_q;
    line_len_d   = line_len_q;
    overflow_d   = overflow_q;
    wr_en_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (line_ready_q) begin
          state_d = ST_LOCKED;
        end else if (!kb_empty_s) begin
          state_d = ST_POP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_POP: begin
        byte_d  = kb_data[7:0];
        state_d = ST_APPLY;
      end
      ST_APPLY: begin
        state_d = ST_IDLE;
        if (break_pend_q) begin
          break_pend_d = 1'b0;
        end else begin
          case (classify(byte_q))
            CLS_BREAK: break_pend_d = 1'b1;
            CLS_BS: begin
              if (line_len_q != '0) begin
                line_len_d = line_len_q - LEN_ONE;
              end else begin
                line_len_d = line_len_q;
              end
            end
            CLS_CR: line_ready_d = 1'b1;
            CLS_PRINT: begin
              if (line_len_q < LEN_MAX) begin
                wr_en_s    = 1'b1;
                line_len_d = line_len_q + LEN_ONE;
              end else begin
                overflow_d = 1'b1;
              end
            end
            default: break_pend_d = break_pend_q;
          endcase
        end
      end
      ST_LOCKED: begin
        // Clear on ack, then leave once the cleared flag is visible.
        if (line_ack) begin
          line_ready_d = 1'b0;
          line_len_d   = '0;
          overflow_d   = 1'b0;
        end else begin
          line_ready_d = line_ready_q;
        end
        if (!line_ready_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    fifo_rd_d = (state_d == ST_POP);
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      byte_q       <= 8'h00;
      break_pend_q <= 1'b0;
      line_ready_q <= 1'b0;
      line_len_q   <= '0;
      overflow_q   <= 1'b0;
      fifo_rd_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_q       <= byte_d;
      break_pend_q <= break_pend_d;
      line_ready_q <= line_ready_d;
      line_len_q   <= line_len_d;
      overflow_q   <= overflow_d;
      fifo_rd_q    <= fifo_rd_d;
    end
  end

  line_ram #(
    .LINE_LEN(LINE_LEN),
    .AW      (AW)
  ) u_ram (
    .clk_i    (clk),
    .rst_i    (rst),
    .wr_en_i  (wr_en_s),
    .wr_addr_i(line_len_q[AW-1:0]),
    .wr_data_i(byte_q),
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_char)
  );

  assign fifo_rd    = fifo_rd_q;
  assign line_ready = line_ready_q;
  assign line_len   = line_len_q;
  assign overflow   = overflow_q;

endmodule
